// File: rtl/alarm_pkg.sv
// Shared types, default timing constants and width helpers for the alarm sequencer.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RING   = 2'b01,
    SNOOZE = 2'b10
  } alarm_state_t;

  localparam int DEF_SNOOZE_SEC       = 540;
  localparam int DEF_RING_TIMEOUT_SEC = 300;
  localparam int DEF_MAX_SNOOZES      = 3;

  // Countdown must hold the longer of the two periods.
  function automatic int sec_width(input int snooze_sec, input int ring_sec);
    int longest;
    longest = (snooze_sec > ring_sec) ? snooze_sec : ring_sec;
    return $clog2(longest + 1);
  endfunction

  // Keep at least one bit so MAX_SNOOZES=0 still yields a legal vector.
  function automatic int snz_width(input int max_snoozes);
    return (max_snoozes > 0) ? $clog2(max_snoozes + 1) : 1;
  endfunction

endpackage

// File: rtl/alarm_sequencer_if.sv
// Event inputs and generator/status outputs of the alarm sequencer.
interface alarm_sequencer_if #(
  parameter int SEC_W = alarm_pkg::sec_width(alarm_pkg::DEF_SNOOZE_SEC, alarm_pkg::DEF_RING_TIMEOUT_SEC),
  parameter int SNZ_W = alarm_pkg::snz_width(alarm_pkg::DEF_MAX_SNOOZES)
);
  logic             sec_tick;
  logic             alarm_en;
  logic             alarm_match;
  logic             snooze_btn;
  logic             dismiss_btn;
  logic             gen_start;
  logic             gen_stop;
  logic             ringing;
  logic             snooze_active;
  logic [SNZ_W-1:0] snooze_count;
  logic [SEC_W-1:0] sec_left;
  logic             missed;

  modport master (
    output sec_tick, alarm_en, alarm_match, snooze_btn, dismiss_btn,
    input  gen_start, gen_stop, ringing, snooze_active, snooze_count, sec_left, missed
  );

  modport slave (
    input  sec_tick, alarm_en, alarm_match, snooze_btn, dismiss_btn,
    output gen_start, gen_stop, ringing, snooze_active, snooze_count, sec_left, missed
  );
endinterface

// File: rtl/alarm_sequencer_sec_countdown.sv
// Loadable seconds down-counter; saturates at zero, clear beats load beats tick.
module sec_countdown #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         expire
);

  logic [W-1:0] count_r;

  // Count register: clear, reload, or decrement on a tick while non-zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_val;
    end else if (tick && (count_r != '0)) begin
      count_r <= count_r - W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count  = count_r;
  assign expire = tick & (count_r == W'(1));

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm ring/snooze/dismiss controller driving the tone pattern generator's start/stop.
module alarm_sequencer
  import alarm_pkg::*;
#(
  parameter int SNOOZE_SEC       = DEF_SNOOZE_SEC,
  parameter int RING_TIMEOUT_SEC = DEF_RING_TIMEOUT_SEC,
  parameter int MAX_SNOOZES      = DEF_MAX_SNOOZES,
  parameter int SEC_W            = sec_width(SNOOZE_SEC, RING_TIMEOUT_SEC),
  parameter int SNZ_W            = snz_width(MAX_SNOOZES)
) (
  input logic               clk,
  input logic               rst_n,
  alarm_sequencer_if.slave  bus
);

  alarm_state_t     state_r, next_state_s;
  logic [SNZ_W-1:0] snz_cnt_r, next_snz_cnt_s;
  logic             missed_r, next_missed_s;
  logic             gen_start_r, gen_stop_r, ringing_r, snooze_active_r;
  logic             load_s, clr_s, expire_s;
  logic [SEC_W-1:0] load_val_s, count_s;

  sec_countdown #(.W(SEC_W)) u_countdown (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_s),
    .load_val (load_val_s),
    .tick     (bus.sec_tick),
    .clr      (clr_s),
    .count    (count_s),
    .expire   (expire_s)
  );

  // Next-state and counter control, events resolved in priority order.
  always_comb begin
    next_state_s   = state_r;
    next_snz_cnt_s = snz_cnt_r;
    next_missed_s  = missed_r;
    load_s         = 1'b0;
    load_val_s     = '0;
    clr_s          = 1'b0;
    case (state_r)
      IDLE: begin
        if (!bus.alarm_en) begin
          next_state_s = IDLE;
        end else if (bus.dismiss_btn) begin
          next_missed_s = 1'b0;
        end else if (bus.alarm_match) begin
          next_state_s   = RING;
          load_s         = 1'b1;
          load_val_s     = SEC_W'(RING_TIMEOUT_SEC);
          next_snz_cnt_s = '0;
          next_missed_s  = 1'b0;
        end else begin
          next_state_s = IDLE;
        end
      end
      RING: begin
        if (!bus.alarm_en || bus.dismiss_btn) begin
          next_state_s = IDLE;
        end else if (bus.snooze_btn && (snz_cnt_r < SNZ_W'(MAX_SNOOZES))) begin
          next_state_s   = SNOOZE;
          load_s         = 1'b1;
          load_val_s     = SEC_W'(SNOOZE_SEC);
          next_snz_cnt_s = snz_cnt_r + SNZ_W'(1);
        end else if (expire_s) begin
          next_state_s  = IDLE;
          next_missed_s = 1'b1;
        end else begin
          next_state_s = RING;
        end
      end
      SNOOZE: begin
        if (!bus.alarm_en || bus.dismiss_btn) begin
          next_state_s = IDLE;
        end else if (expire_s) begin
          next_state_s = RING;
          load_s       = 1'b1;
          load_val_s   = SEC_W'(RING_TIMEOUT_SEC);
        end else begin
          next_state_s = SNOOZE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
    // Every path into IDLE parks the countdown and forgets the snooze history.
    if (next_state_s == IDLE) begin
      clr_s          = 1'b1;
      next_snz_cnt_s = '0;
    end else begin
      clr_s = 1'b0;
    end
  end

  // State and registered outputs; gen_start marks only the first RING cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= IDLE;
      snz_cnt_r       <= '0;
      missed_r        <= 1'b0;
      gen_start_r     <= 1'b0;
      gen_stop_r      <= 1'b1;
      ringing_r       <= 1'b0;
      snooze_active_r <= 1'b0;
    end else begin
      state_r         <= next_state_s;
      snz_cnt_r       <= next_snz_cnt_s;
      missed_r        <= next_missed_s;
      gen_start_r     <= (next_state_s == RING) && (state_r != RING);
      gen_stop_r      <= (next_state_s != RING);
      ringing_r       <= (next_state_s == RING);
      snooze_active_r <= (next_state_s == SNOOZE);
    end
  end

  assign bus.gen_start     = gen_start_r;
  assign bus.gen_stop      = gen_stop_r;
  assign bus.ringing       = ringing_r;
  assign bus.snooze_active = snooze_active_r;
  assign bus.snooze_count  = snz_cnt_r;
  assign bus.sec_left      = count_s;
  assign bus.missed        = missed_r;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Table-driven, hand-written and randomized checks of alarm_sequencer against a behavioural model.
module tb_alarm_sequencer;

  localparam int SS  = 3;
  localparam int RT  = 5;
  localparam int MAX = 2;

  typedef struct {
    bit en, match, snz, dis, tick;
    bit start, stop, ring, sact;
    int cnt, left;
    bit missed;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Behavioural model: mode 0 quiet, 1 ringing, 2 snoozing.
  int m_mode, m_left, m_snz;
  bit m_missed, m_start;

  vec_t vecs[$];

  alarm_sequencer_if #(.SEC_W(3), .SNZ_W(2)) bus ();

  alarm_sequencer #(.SNOOZE_SEC(SS), .RING_TIMEOUT_SEC(RT), .MAX_SNOOZES(MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input bit start, input bit stop, input bit ring,
                         input bit sact, input int cnt, input int left, input bit missed);
    chk({tag, ".gen_start"}, int'(bus.gen_start), int'(start));
    chk({tag, ".gen_stop"}, int'(bus.gen_stop), int'(stop));
    chk({tag, ".ringing"}, int'(bus.ringing), int'(ring));
    chk({tag, ".snooze_active"}, int'(bus.snooze_active), int'(sact));
    chk({tag, ".snooze_count"}, int'(bus.snooze_count), cnt);
    chk({tag, ".sec_left"}, int'(bus.sec_left), left);
    chk({tag, ".missed"}, int'(bus.missed), int'(missed));
  endtask

  task automatic model_reset();
    m_mode = 0; m_left = 0; m_snz = 0; m_missed = 1'b0; m_start = 1'b0;
  endtask

  task automatic model_step(input bit en, input bit match, input bit snz, input bit dis, input bit tick);
    int prev;
    prev = m_mode;
    if (!en) m_mode = 0;
    else if (m_mode == 0) begin
      if (dis) m_missed = 1'b0;
      else if (match) begin m_mode = 1; m_left = RT; m_snz = 0; m_missed = 1'b0; end
    end else if (dis) m_mode = 0;
    else if (m_mode == 1 && snz && m_snz < MAX) begin m_mode = 2; m_snz++; m_left = SS; end
    else if (tick && m_left == 1) begin
      if (m_mode == 1) begin m_mode = 0; m_missed = 1'b1; end
      else begin m_mode = 1; m_left = RT; end
    end else if (tick && m_left > 0) m_left--;
    if (m_mode == 0) begin m_left = 0; m_snz = 0; end
    m_start = (m_mode == 1) && (prev != 1);
  endtask

  task automatic model_check(input string tag);
    chk_out(tag, m_start, m_mode != 1, m_mode == 1, m_mode == 2, m_snz, m_left, m_missed);
  endtask

  // One clock: drive at negedge, model advances with the edge, sample 1ns later, drop pulses.
  task automatic step(input bit en, input bit match, input bit snz, input bit dis, input bit tick);
    @(negedge clk);
    bus.alarm_en = en; bus.alarm_match = match; bus.snooze_btn = snz;
    bus.dismiss_btn = dis; bus.sec_tick = tick;
    @(posedge clk);
    model_step(en, match, snz, dis, tick);
    #1;
    bus.alarm_match = 1'b0; bus.snooze_btn = 1'b0; bus.dismiss_btn = 1'b0; bus.sec_tick = 1'b0;
  endtask

  function automatic void add(input bit en, input bit match, input bit snz, input bit dis, input bit tick,
                              input bit start, input bit stop, input bit ring, input bit sact,
                              input int cnt, input int left, input bit missed);
    vec_t v;
    v.en = en; v.match = match; v.snz = snz; v.dis = dis; v.tick = tick;
    v.start = start; v.stop = stop; v.ring = ring; v.sact = sact;
    v.cnt = cnt; v.left = left; v.missed = missed;
    vecs.push_back(v);
  endfunction

  initial begin
    //   en m  s  d  t    start stop ring sact cnt left missed
    add(1, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0,   1, 0, 1, 0, 0, 5, 0);
    add(1, 0, 0, 0, 1,   0, 0, 1, 0, 0, 4, 0);
    add(1, 0, 0, 0, 1,   0, 0, 1, 0, 0, 3, 0);
    add(1, 0, 0, 0, 1,   0, 0, 1, 0, 0, 2, 0);
    add(1, 0, 0, 0, 1,   0, 0, 1, 0, 0, 1, 0);
    add(1, 0, 0, 0, 1,   0, 1, 0, 0, 0, 0, 1);
    add(1, 1, 0, 0, 0,   1, 0, 1, 0, 0, 5, 0);
    add(1, 0, 1, 0, 0,   0, 1, 0, 1, 1, 3, 0);
    add(1, 0, 0, 0, 1,   0, 1, 0, 1, 1, 2, 0);
    add(1, 0, 0, 0, 1,   0, 1, 0, 1, 1, 1, 0);
    add(1, 0, 0, 0, 1,   1, 0, 1, 0, 1, 5, 0);
    add(1, 0, 1, 0, 0,   0, 1, 0, 1, 2, 3, 0);
    add(1, 0, 0, 0, 1,   0, 1, 0, 1, 2, 2, 0);
    add(1, 0, 0, 0, 1,   0, 1, 0, 1, 2, 1, 0);
    add(1, 0, 0, 0, 1,   1, 0, 1, 0, 2, 5, 0);
    add(1, 0, 1, 0, 0,   0, 0, 1, 0, 2, 5, 0);
    add(1, 0, 1, 0, 1,   0, 0, 1, 0, 2, 4, 0);
    add(1, 0, 0, 1, 0,   0, 1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0,   1, 0, 1, 0, 0, 5, 0);
    add(1, 0, 1, 1, 0,   0, 1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0,   1, 0, 1, 0, 0, 5, 0);
    add(1, 0, 0, 0, 1,   0, 0, 1, 0, 0, 4, 0);
    add(1, 0, 0, 0, 1,   0, 0, 1, 0, 0, 3, 0);
    add(1, 0, 0, 0, 1,   0, 0, 1, 0, 0, 2, 0);
    add(1, 0, 0, 0, 1,   0, 0, 1, 0, 0, 1, 0);
    add(1, 0, 0, 1, 1,   0, 1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 1,   1, 0, 1, 0, 0, 5, 0);
    add(1, 0, 1, 0, 0,   0, 1, 0, 1, 1, 3, 0);
    add(0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1,   0, 1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0,   1, 0, 1, 0, 0, 5, 0);
    add(1, 0, 0, 0, 1,   0, 0, 1, 0, 0, 4, 0);
    add(1, 0, 0, 0, 1,   0, 0, 1, 0, 0, 3, 0);
    add(1, 0, 0, 0, 1,   0, 0, 1, 0, 0, 2, 0);
    add(1, 0, 0, 0, 1,   0, 0, 1, 0, 0, 1, 0);
    add(1, 0, 0, 0, 1,   0, 1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0,   0, 1, 0, 0, 0, 0, 1);
    add(1, 0, 0, 1, 0,   0, 1, 0, 0, 0, 0, 0);

    bus.alarm_en = 1'b0; bus.alarm_match = 1'b0; bus.snooze_btn = 1'b0;
    bus.dismiss_btn = 1'b0; bus.sec_tick = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_out("reset", 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].match, vecs[i].snz, vecs[i].dis, vecs[i].tick);
      chk_out($sformatf("vec%0d", i), vecs[i].start, vecs[i].stop, vecs[i].ring,
              vecs[i].sact, vecs[i].cnt, vecs[i].left, vecs[i].missed);
    end

    // Asynchronous reset between edges while ringing.
    step(1, 1, 0, 0, 0);
    model_check("pre_rst_ring");
    step(1, 0, 0, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_out("async_rst", 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 1, 0, 0, 0);
    chk_out("post_rst_ring", 1'b1, 1'b0, 1'b1, 1'b0, 0, 5, 1'b0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      step(($urandom % 32) != 0, ($urandom % 6) == 0, ($urandom % 8) == 0,
           ($urandom % 25) == 0, ($urandom % 3) == 0);
      model_check($sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
